// File: rtl/inst_fetcher.sv
// Instruction fetch front end: icache lookup at PC, miss refill via the memory
// controller, and a one-entry output buffer toward the decoder.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ic_to_if_hit,
  input  logic [31:0] ic_to_if_hit_inst,
  output logic [31:0] if_to_ic_inst_addr,
  output logic        if_to_ic_ready,
  output logic [31:0] if_to_ic_inst,
  output logic        if_to_ic_inst_valid,
  output logic        if_to_mc_req,
  output logic [31:0] if_to_mc_addr,
  input  logic        mc_to_if_done,
  input  logic [31:0] mc_to_if_inst,
  output logic        if_to_dc_valid,
  output logic [31:0] if_to_dc_inst,
  output logic [31:0] if_to_dc_pc,
  input  logic        dc_to_if_ready,
  input  logic        rob_to_if_clear,
  input  logic [31:0] rob_to_if_new_pc
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, FILL, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] fill_q, fill_d;
  logic        buf_vld_q, buf_vld_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        can_accept;

  assign can_accept          = !buf_vld_q || dc_to_if_ready;
  assign if_to_ic_ready      = (state_q == IDLE) && can_accept && !rob_to_if_clear;
  assign if_to_ic_inst_addr  = (state_q == FILL) ? pend_q : pc_q;
  assign if_to_ic_inst       = fill_q;
  assign if_to_ic_inst_valid = (state_q == FILL);
  assign if_to_mc_req        = (state_q == MEM_WAIT) || (state_q == DRAIN);
  assign if_to_mc_addr       = pend_q;
  assign if_to_dc_valid      = buf_vld_q;
  assign if_to_dc_inst       = buf_inst_q;
  assign if_to_dc_pc         = buf_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    fill_d     = fill_q;
    buf_vld_d  = buf_vld_q && !dc_to_if_ready;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    if (rob_to_if_clear) begin
      // Redirect wins; an outstanding memory request must still be drained.
      buf_vld_d = 1'b0;
      pc_d      = rob_to_if_new_pc;
      case (state_q)
        MEM_WAIT, DRAIN: state_d = mc_to_if_done ? IDLE : DRAIN;
        default:         state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (if_to_ic_ready) begin
            if (ic_to_if_hit) begin
              buf_vld_d  = 1'b1;
              buf_inst_d = ic_to_if_hit_inst;
              buf_pc_d   = pc_q;
              pc_d       = pc_q + 32'd4;
            end else begin
              pend_d  = pc_q;
              state_d = MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mc_to_if_done) begin
            fill_d  = mc_to_if_inst;
            state_d = FILL;
          end
        end
        FILL:    state_d = IDLE;
        DRAIN:   if (mc_to_if_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 32'h0;
      fill_q     <= 32'h0;
      buf_vld_q  <= 1'b0;
      buf_inst_q <= 32'h0;
      buf_pc_q   <= 32'h0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      fill_q     <= fill_d;
      buf_vld_q  <= buf_vld_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameter RESET_PC, default 32'h0, fetch PC loaded on reset.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low freezes all state and holds all outputs.
REQ-005 ic_to_if_hit  input  1  icache hit for if_to_ic_inst_addr, same cycle.
REQ-006 ic_to_if_hit_inst  input  32  hit instruction, same cycle.
REQ-007 if_to_ic_inst_addr  output  32  lookup/fill address (= PC, or the fill address in FILL).
REQ-008 if_to_ic_ready  output  1  lookup enable.
REQ-009 if_to_ic_inst  output  32  fill instruction.
REQ-010 if_to_ic_inst_valid  output  1  fill write strobe, one cycle.
REQ-011 if_to_mc_req  output  1  memory fetch request, level.
REQ-012 if_to_mc_addr  output  32  memory fetch address.
REQ-013 mc_to_if_done  input  1  one-cycle pulse: data valid.
REQ-014 mc_to_if_inst  input  32  fetched instruction, valid with done.
REQ-015 if_to_dc_valid  output  1  instruction buffer valid.
REQ-016 if_to_dc_inst  output  32  buffered instruction.
REQ-017 if_to_dc_pc  output  32  PC of buffered instruction.
REQ-018 dc_to_if_ready  input  1  decoder accepts buffer this cycle.
REQ-019 rob_to_if_clear  input  1  flush/redirect pulse.
REQ-020 rob_to_if_new_pc  input  32  redirect target, valid with clear.

Function
REQ-021 States: IDLE, MEM_WAIT, FILL, DRAIN; registered state, PC, pending address, fill data, one-entry output buffer.
REQ-022 can_accept = !if_to_dc_valid || dc_to_if_ready.
REQ-023 Buffer handoff: entry consumed on cycle where if_to_dc_valid && dc_to_if_ready; outputs stable while valid && !ready.
REQ-024 IDLE: if_to_ic_ready = can_accept && !rob_to_if_clear; if_to_ic_inst_addr = PC.
REQ-025 IDLE hit with if_to_ic_ready: next cycle buffer = {ic_to_if_hit_inst, PC}, valid=1; PC <= PC+4 (mod 2^32); stays IDLE; sustains one instruction per cycle.
REQ-026 IDLE miss with if_to_ic_ready: pending address <= PC; go MEM_WAIT; if_to_mc_req=1 from next cycle.
REQ-027 MEM_WAIT: if_to_mc_req=1, if_to_mc_addr = pending address; on mc_to_if_done capture mc_to_if_inst, go FILL.
REQ-028 FILL (one cycle): if_to_ic_inst_valid=1, if_to_ic_inst_addr = pending address, if_to_ic_inst = captured data, if_to_mc_req=0; then IDLE; PC unchanged; re-lookup hits.
REQ-029 if_to_mc_req deasserts the cycle after done; never high in IDLE or FILL.
REQ-030 rob_to_if_clear has priority over all: buffer valid <= 0, PC <= rob_to_if_new_pc; IDLE/FILL -> IDLE (FILL strobe in that cycle still completes).
REQ-031 Clear in MEM_WAIT without done: go DRAIN; request stays high at old pending address until done; data discarded (no fill); then IDLE at new PC.
REQ-032 Clear in MEM_WAIT coincident with done, or in DRAIN: data discarded, go IDLE.
REQ-033 Additional clear in DRAIN: PC updated to latest target; stays DRAIN.
REQ-034 Hit in same cycle as clear: ignored (lookup disabled per REQ-024).
REQ-035 rdy_in low: no state change; mc_to_if_done during rdy_in low is the controller's responsibility to hold off.

Reset
REQ-036 rst_in high at edge: PC=RESET_PC, state IDLE, buffer valid=0, buffer inst/pc=0, pending address=0, fill data=0; reset overrides rdy_in.
REQ-037 Reset-state outputs: if_to_mc_req=0, if_to_ic_inst_valid=0, if_to_dc_valid=0; if_to_ic_ready=1 after reset release.

Verification
REQ-038 Reset, all hits (ic_inst=PC^32'hA5A5_0000), dc ready=1 -> if_to_dc_pc 0,4,8,12 on consecutive cycles, correct insts.
REQ-039 Miss at PC 0x100, done 3 cycles later with 0x00000013 -> req high 3 cycles, addr 0x100; one fill strobe addr 0x100 data 0x13; buffer shows {0x13,0x100} after hit.
REQ-040 Buffer valid, dc ready=0 for 4 cycles -> outputs constant, PC unchanged, no lookup; ready=1 -> resumes next PC.
REQ-041 Clear to 0x200 during MEM_WAIT (addr 0x100) -> req held at 0x100 until done, no fill; next lookup at 0x200; no 0x100 instruction delivered.
REQ-042 Clear with buffer valid and hit same cycle -> buffer valid 0 next cycle, PC=new_pc, hit dropped.
REQ-043 rdy_in low 5 cycles mid-stream -> all outputs frozen; stream continues unchanged on rdy_in high.
